sinx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one sinx accelerator among NUM_REQ requesters.
- Accepts a 16-bit x operand from one requester per transaction and pulses the core start.
- Waits for the core done, then returns the 16-bit result to the same requester over a valid/ready response handshake.
- Sits between the requester agents and the single sinx instance; it is the only driver of that core's start and x inputs.

---
 rtl/sinx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sinx_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sinx_arbiter.sv
// -----------------------------------------------------------------------------
// sinx_arbiter
//
// Round-robin arbiter and sequencer that shares one sinx accelerator among
// NUM_REQ requesters. One transaction is in flight at a time:
//   IDLE  -> pick a winner (round robin from last_grant+1), latch its operand
//   ISSUE -> one-cycle core start pulse
//   WAIT  -> wait for core done (optionally bounded by a timeout)
//   RESP  -> present the result to the owner until it accepts it
//
// Optional feature macro: SINX_ARB_TIMEOUT_EN
//   Defined   : WAIT aborts after TIMEOUT_CYCLES cycles without core done and
//               answers with result 16'h0000 and rsp_err_o=1.
//   Undefined : WAIT waits indefinitely; rsp_err_o is always 0.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    per-requester request valid
//   req_x_i        per-requester 16-bit operand, requester r at [16r+15:16r]
//   req_ready_o    one-hot request accept (IDLE only)
//   rsp_valid_o    one-hot response valid (RESP only)
//   rsp_ready_i    per-requester response ready
//   rsp_result_o   result for the requester flagged in rsp_valid_o
//   rsp_err_o      timeout flag, qualified by rsp_valid_o
//   core_start_o   one-cycle start pulse to the sinx core
//   core_x_o       operand to the sinx core
//   core_result_i  sinx core result
//   core_done_i    sinx core done
//   busy_o         high whenever the sequencer is not idle
//   grant_id_o     index of the current owner
// -----------------------------------------------------------------------------
module sinx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [16*NUM_REQ-1:0]              req_x_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    input  logic [NUM_REQ-1:0]                 rsp_ready_i,
    output logic [15:0]                        rsp_result_o,
    output logic                               rsp_err_o,
    output logic                               core_start_o,
    output logic [15:0]                        core_x_o,
    input  logic [15:0]                        core_result_i,
    input  logic                               core_done_i,
    output logic                               busy_o,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id_o
);

    localparam int GW = $clog2(NUM_REQ);

    // Parameter sanity checks at elaboration time.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("sinx_arbiter: NUM_REQ must be in 2..8");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("sinx_arbiter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [GW-1:0]   last_grant_reg;
    logic [GW-1:0]   grant_id_reg;
    logic [15:0]     x_reg;
    logic            start_reg;
    logic [15:0]     result_reg;
    logic            err_reg;

`ifdef SINX_ARB_TIMEOUT_EN
    // At least 8 bits wide, and wide enough to hold TIMEOUT_CYCLES.
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0]   wait_cnt_reg;
`endif

    // -------------------------------------------------------------------------
    // Operand slices and round-robin candidate order
    // -------------------------------------------------------------------------
    logic [15:0]     x_slice  [NUM_REQ];
    logic [GW-1:0]   cand_idx [NUM_REQ];   // cand_idx[k] = (last_grant + 1 + k) mod NUM_REQ

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign x_slice[gi]  = req_x_i[16*gi +: 16];
            assign cand_idx[gi] = GW'((int'(last_grant_reg) + gi + 1) % NUM_REQ);
        end
    endgenerate

    // Winner search. Walking the candidate list from the far end and letting
    // later hits overwrite earlier ones leaves the candidate closest to
    // last_grant+1 as the winner.
    logic            win_found;
    logic [GW-1:0]   win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // One-hot handshake outputs
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign req_ready_o[gi] = (state_reg == IDLE) && win_found && (win_idx == GW'(gi));
            assign rsp_valid_o[gi] = (state_reg == RESP) && (grant_id_reg == GW'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            // Pointer at the top index so requester 0 is searched first.
            last_grant_reg <= GW'(NUM_REQ - 1);
            grant_id_reg   <= '0;
            x_reg          <= '0;
            start_reg      <= 1'b0;
            result_reg     <= '0;
            err_reg        <= 1'b0;
`ifdef SINX_ARB_TIMEOUT_EN
            wait_cnt_reg   <= '0;
`endif
        end else begin
            // The start pulse is raised only on the IDLE->ISSUE edge, so it
            // is high for exactly the ISSUE cycle.
            start_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        x_reg        <= x_slice[win_idx];
                        grant_id_reg <= win_idx;
                        start_reg    <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end

                ISSUE: begin
                    // core_done_i is deliberately not looked at here.
`ifdef SINX_ARB_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                    state_reg <= WAIT;
                end

                WAIT: begin
                    // A done arriving in the timeout cycle still wins.
                    if (core_done_i) begin
                        result_reg <= core_result_i;
                        err_reg    <= 1'b0;
                        state_reg  <= RESP;
                    end
`ifdef SINX_ARB_TIMEOUT_EN
                    else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                        result_reg <= 16'h0000;
                        err_reg    <= 1'b1;
                        state_reg  <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end

                RESP: begin
                    // Only the owner's ready bit matters.
                    if (rsp_ready_i[grant_id_reg]) begin
                        last_grant_reg <= grant_id_reg;
                        state_reg      <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign core_start_o = start_reg;
    assign core_x_o     = x_reg;
    assign rsp_result_o = result_reg;
    assign rsp_err_o    = err_reg;
    assign grant_id_o   = grant_id_reg;
    assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_sinx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sinx_arbiter
//
// Self-checking bench for sinx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=64).
// A transaction-level reference model (owner, age of the transaction, pending
// response, round-robin pointer) predicts every DUT output each cycle; a few
// directed scenarios additionally pin literal values. A simple core model
// answers start pulses after a programmable latency and can inject
// spurious done pulses. Build with +define+SINX_ARB_TIMEOUT_EN to exercise
// the timeout variant.
// -----------------------------------------------------------------------------
module tb_sinx_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_x = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [15:0]     rsp_result;
    logic            rsp_err;
    logic            core_start;
    logic [15:0]     core_x;
    logic [15:0]     core_result = '0;
    logic            core_done = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    sinx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_x_i       (req_x),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_result_o  (rsp_result),
        .rsp_err_o     (rsp_err),
        .core_start_o  (core_start),
        .core_x_o      (core_x),
        .core_result_i (core_result),
        .core_done_i   (core_done),
        .busy_o        (busy),
        .grant_id_o    (grant_id)
    );

    int checks   = 0;
    int failures = 0;

    // Core model controls
    int          core_lat   = 3;     // 0 = never answers
    int          countdown  = 0;
    logic [15:0] core_val   = '0;
    bit          spur_en    = 1'b0;
    bit          force_done = 1'b0;

    // Reference model state
    bit          m_busy;
    bit          m_resp;
    int          m_owner;
    int          m_lg;
    int          m_age;              // 1 in the start cycle, 2.. while waiting
    logic [15:0] m_x;
    logic [15:0] m_res;
    logic        m_err;
    int          m_gid;
    int          m_win;
    int          n_done = 0;

    // Snapshot of DUT outputs from the last step
    logic [N-1:0] s_ready, s_rspv;
    logic [15:0]  s_res, s_x;
    logic         s_err, s_start, s_busy;
    int           s_gid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sinx_fake(input logic [15:0] x);
        if (x == 16'h0800) return 16'h07A6;
        return x * 16'd5 + 16'h1234;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int lg);
        for (int k = 1; k <= N; k++) begin
            if (v[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_resp = 1'b0; m_owner = 0; m_lg = N - 1; m_age = 0;
        m_x = '0; m_res = '0; m_err = 1'b0; m_gid = 0;
    endtask

    // One clock cycle: drive core, compare, advance the model across the edge.
    task automatic step();
        core_done   = 1'b0;
        core_result = 16'($urandom);
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                core_done   = 1'b1;
                core_result = core_val;
            end
        end else if (spur_en && $urandom_range(0, 15) == 0) begin
            core_done = 1'b1;
        end
        if (force_done) begin
            core_done   = 1'b1;
            core_result = 16'hDEAD;
        end
        #1;
        m_win = m_busy ? -1 : pick(req_valid, m_lg);
        check("req_ready",  32'(req_ready),  (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
        check("rsp_valid",  32'(rsp_valid),  m_resp ? (32'd1 << m_owner) : 32'd0);
        check("busy",       32'(busy),       32'(m_busy));
        check("core_start", 32'(core_start), 32'(m_busy && m_age == 1));
        check("core_x",     32'(core_x),     32'(m_x));
        check("rsp_result", 32'(rsp_result), 32'(m_res));
        check("rsp_err",    32'(rsp_err),    32'(m_err));
        check("grant_id",   32'(grant_id),   32'(m_gid));
        s_ready = req_ready; s_rspv = rsp_valid; s_res = rsp_result; s_x = core_x;
        s_err = rsp_err; s_start = core_start; s_busy = busy; s_gid = int'(grant_id);
        if (core_start && core_lat > 0) begin
            countdown = core_lat;
            core_val  = sinx_fake(core_x);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (m_win >= 0) begin
                m_busy = 1'b1; m_owner = m_win; m_gid = m_win; m_age = 1;
                m_x = req_x[16*m_win +: 16];
            end
        end else if (!m_resp) begin
            if (m_age >= 2 && core_done) begin
                m_resp = 1'b1; m_res = core_result; m_err = 1'b0;
            end
`ifdef SINX_ARB_TIMEOUT_EN
            else if (m_age - 2 == TO - 1) begin
                m_resp = 1'b1; m_res = 16'h0000; m_err = 1'b1;
            end
`endif
            m_age++;
        end else if (rsp_ready[m_owner]) begin
            $display("txn owner=%0d x=%h result=%h err=%0d", m_owner, m_x, m_res, m_err);
            m_busy = 1'b0; m_resp = 1'b0; m_lg = m_owner; n_done++;
        end
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req_valid = '0; rsp_ready = '0; countdown = 0; force_done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (s_rspv == '0 && cycles < limit);
        check("rsp_arrived", 32'(s_rspv != '0), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int k;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        model_reset();
        #1;

        // ---- Reset state and single request from requester 2 ----
        reset_dut();
        step();
        check("rst_gid",   32'(s_gid),   32'd0);
        check("rst_x",     32'(s_x),     32'd0);
        check("rst_busy",  32'(s_busy),  32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        core_lat = 5;
        req_valid = 4'b0100; req_x[47:32] = 16'h0800;
        step();
        check("t1_ready", 32'(s_ready), 32'h4);
        req_valid = '0;
        step();
        check("t1_start", 32'(s_start), 32'd1);
        check("t1_x",     32'(s_x),     32'h0800);
        wait_rsp(20, c);
        check("t1_lat",   32'(c),      32'd6);
        check("t1_rspv",  32'(s_rspv), 32'h4);
        check("t1_res",   32'(s_res),  32'h07A6);
        check("t1_gid",   32'(s_gid),  32'd2);
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;
        step();
        check("t1_idle", 32'(s_busy), 32'd0);

        // ---- Fairness: all valid, grants 0,1,2,3,0 ----
        reset_dut();
        core_lat = 1; rsp_ready = '1; req_valid = '1;
        req_x = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        k = 0;
        for (int cy = 0; cy < 100 && k < 5; cy++) begin
            step();
            if (s_start) begin
                check("fair_gid", 32'(s_gid), 32'(order[k]));
                check("fair_x",   32'(s_x),   32'(order[k] + 1));
                k++;
            end
        end
        check("fair_count", 32'(k), 32'd5);

        // ---- Response backpressure on requester 1 ----
        reset_dut();
        core_lat = 2; rsp_ready = 4'b1101; req_valid = 4'b0010; req_x[31:16] = 16'h0042;
        step();
        req_valid = 4'b0001;
        wait_rsp(20, c);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_rspv",  32'(s_rspv),  32'h2);
            check("bp_res",   32'(s_res),   32'h137E);
            check("bp_ready", 32'(s_ready), 32'd0);
        end
        rsp_ready = '1;
        step();
        step();
        check("bp_idle_busy",  32'(s_busy),  32'd0);
        check("bp_idle_ready", 32'(s_ready), 32'h1);
        req_valid = '0;
        for (int i = 0; i < 8; i++) step();

        // ---- Reset during WAIT ----
        reset_dut();
        core_lat = 1; rsp_ready = '1; req_valid = 4'b0010;
        step();
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();   // requester 1 completes, pointer at 1
        core_lat = 5; req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();                                // start cycle
        step();                                // first wait cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();   // late core done lands here
        check("rw_rspv", 32'(s_rspv), 32'd0);
        check("rw_busy", 32'(s_busy), 32'd0);
        req_valid = '1;
        step();
        check("rw_next", 32'(s_ready), 32'h1);
        req_valid = '0;
        for (int i = 0; i < 10; i++) step();

        // ---- Spurious done in IDLE and in the start cycle ----
        reset_dut();
        core_lat = 3; rsp_ready = '1;
        force_done = 1'b1;
        step();
        req_valid = 4'b0001; req_x[15:0] = 16'h0100;
        step();
        req_valid = '0;
        step();
        force_done = 1'b0;
        wait_rsp(20, c);
        check("sp_lat", 32'(c),     32'd4);
        check("sp_res", 32'(s_res), 32'h1734);
        check("sp_err", 32'(s_err), 32'd0);
        step();

        // ---- Core never answers ----
        reset_dut();
        core_lat = 0; rsp_ready = '1; req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
`ifdef SINX_ARB_TIMEOUT_EN
        wait_rsp(200, c);
        check("to_lat", 32'(c),     32'd65);
        check("to_res", 32'(s_res), 32'h0);
        check("to_err", 32'(s_err), 32'd1);
        step();
`else
        for (int i = 0; i < 1000; i++) step();
        check("nto_busy", 32'(s_busy), 32'd1);
        check("nto_rspv", 32'(s_rspv), 32'd0);
`endif

        // ---- Randomized traffic ----
        reset_dut();
        spur_en = 1'b1;
        for (int cy = 0; cy < 4000; cy++) begin
            for (int r = 0; r < N; r++) begin
                if (req_valid[r] && s_ready[r]) begin
                    req_valid[r] = 1'($urandom_range(0, 1));
                    req_x[16*r +: 16] = 16'($urandom);
                end else if (!req_valid[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[r] = 1'b1;
                        req_x[16*r +: 16] = 16'($urandom);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            rsp_ready = N'($urandom);
            core_lat  = $urandom_range(1, 6);
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        spur_en = 1'b0;
        check("rand_activity", 32'(n_done > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
